// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM clock set controller.
// The optional CLOCK_SET_AUTO_REPEAT_EN build uses the same definitions.
package clock_pkg;

    localparam int HOURS_W   = 5;
    localparam int MINUTES_W = 6;

    localparam logic [HOURS_W-1:0]   HOURS_MAX   = 5'd23;
    localparam logic [MINUTES_W-1:0] MINUTES_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2
    } state_t;

    // Out-of-range captured values become 0 so editing always starts legal.
    function automatic logic [HOURS_W-1:0] clamp_hours(input logic [HOURS_W-1:0] h);
        return (h > HOURS_MAX) ? '0 : h;
    endfunction

    function automatic logic [MINUTES_W-1:0] clamp_minutes(input logic [MINUTES_W-1:0] m);
        return (m > MINUTES_MAX) ? '0 : m;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-count debouncer and a
// registered one-cycle press pulse on the debounced rising edge.
// Latency from a clean raw edge to press is DEBOUNCE_CYCLES+3 cycles.
// With CLOCK_SET_AUTO_REPEAT_EN defined the debounced level is also exported.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    output logic level,
`endif
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;
    logic          stable_reg;
    logic          stable_d_reg;
    logic          press_reg;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], btn};
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
        end else if (sync_reg[1] == stable_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg    <= '0;
            stable_reg <= sync_reg[1];
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    // Registered rising-edge detect on the debounced level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d_reg <= 1'b0;
            press_reg    <= 1'b0;
        end else begin
            stable_d_reg <= stable_reg;
            press_reg    <= stable_reg & ~stable_d_reg;
        end
    end

    assign press = press_reg;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    assign level = stable_reg;
`endif

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock set controller: RUN / SET_HOURS / SET_MINUTES editing FSM that
// captures the running time, edits it with the increment button, and loads
// it back with a one-cycle strobe. Also drives run_en and the blink mask.
// Optional build macro: CLOCK_SET_AUTO_REPEAT_EN (auto-repeat while inc held).
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int BLINK_HALF      = 12_500_000,
    parameter int REPEAT_CYCLES   = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    output logic [4:0] set_hours,
    output logic [5:0] set_minutes,
    output logic       load,
    output logic       run_en,
    output logic [1:0] blink_mask,
    output logic [1:0] mode
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    // Index 0 = mode button, index 1 = increment button.
    logic [1:0] btn_raw;
    logic [1:0] btn_press;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    logic [1:0] btn_level;
`endif
    logic mode_p;
    logic inc_p;
    logic bump;

    state_t                state_reg, state_next;
    logic [HOURS_W-1:0]    hours_reg, hours_next;
    logic [MINUTES_W-1:0]  minutes_reg, minutes_next;
    logic                  load_reg, load_next;
    logic [BW-1:0]         blink_cnt_reg;
    logic                  phase_reg;
    logic                  entering_set;

    assign btn_raw = {btn_inc, btn_mode};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_db
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk   (clk),
                .rst   (rst),
                .btn   (btn_raw[gi]),
`ifdef CLOCK_SET_AUTO_REPEAT_EN
                .level (btn_level[gi]),
`endif
                .press (btn_press[gi])
            );
        end
    endgenerate

    assign mode_p = btn_press[0];
    assign inc_p  = btn_press[1];

    // A SET state is being entered fresh (from RUN or from the other SET state).
    assign entering_set = (state_next != state_reg) && (state_next != ST_RUN);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rpt_cnt_reg;
    logic          rpt_hold;

    // Repeat only while inc is held alone in a SET state.
    assign rpt_hold = (state_reg != ST_RUN) && btn_level[1] && !btn_level[0];

    // Repeat timer: restarted by any press, state change or release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt_reg <= '0;
        end else if (!rpt_hold || mode_p || inc_p || (state_next != state_reg)) begin
            rpt_cnt_reg <= '0;
        end else if (rpt_cnt_reg == REPEAT_LAST) begin
            rpt_cnt_reg <= '0;
        end else begin
            rpt_cnt_reg <= rpt_cnt_reg + RW'(1);
        end
    end

    assign bump = inc_p | (rpt_hold && (rpt_cnt_reg == REPEAT_LAST));
`else
    assign bump = inc_p;
`endif

    // Next-state and edit-register logic; mode always beats increment.
    always_comb begin
        state_next   = state_reg;
        hours_next   = hours_reg;
        minutes_next = minutes_reg;
        load_next    = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (mode_p) begin
                    hours_next   = clamp_hours(cur_hours);
                    minutes_next = clamp_minutes(cur_minutes);
                    state_next   = ST_SET_H;
                end
            end
            ST_SET_H: begin
                if (mode_p) begin
                    state_next = ST_SET_M;
                end else if (bump) begin
                    hours_next = (hours_reg == HOURS_MAX) ? '0 : hours_reg + HOURS_W'(1);
                end
            end
            ST_SET_M: begin
                if (mode_p) begin
                    state_next = ST_RUN;
                    load_next  = 1'b1;
                end else if (bump) begin
                    minutes_next = (minutes_reg == MINUTES_MAX) ? '0 : minutes_reg + MINUTES_W'(1);
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // FSM state, edit values and load strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_RUN;
            hours_reg   <= '0;
            minutes_reg <= '0;
            load_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hours_reg   <= hours_next;
            minutes_reg <= minutes_next;
            load_reg    <= load_next;
        end
    end

    // Blink phase: restarts visible on each SET entry, toggles every BLINK_HALF cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (entering_set) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (state_reg != ST_RUN) begin
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg <= '0;
                phase_reg     <= ~phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + BW'(1);
            end
        end
    end

    assign set_hours   = hours_reg;
    assign set_minutes = minutes_reg;
    assign load        = load_reg;
    assign run_en      = (state_reg == ST_RUN);
    assign mode        = state_reg;
    assign blink_mask  = {(state_reg == ST_SET_H) && phase_reg,
                          (state_reg == ST_SET_M) && phase_reg};

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce/blink/repeat periods.
// Expectations for the auto-repeat step follow CLOCK_SET_AUTO_REPEAT_EN.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] cur_hours = 5'd0;
    logic [5:0] cur_minutes = 6'd0;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic       load;
    logic       run_en;
    logic [1:0] blink_mask;
    logic [1:0] mode;

    int errors = 0;
    int checks = 0;
    int load_cnt = 0;
    int load_bad = 0;

    clock_set_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_HALF(8),
        .REPEAT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes),
        .set_hours(set_hours), .set_minutes(set_minutes), .load(load),
        .run_en(run_en), .blink_mask(blink_mask), .mode(mode)
    );

    always #5 clk = ~clk;

    // Count load pulses and flag any load seen while run_en is low.
    always @(negedge clk) begin
        if (load) begin
            load_cnt++;
            if (!run_en) load_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the button(s) long enough for the press to act, then release and settle.
    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        tick(8);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick(8);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        int bad;
        logic [31:0] exp_rpt;

        // 1. reset state and idle hold
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_run_en", run_en, 1);
        check("rst_load", load, 0);
        check("rst_mode", mode, 0);
        check("rst_blink", blink_mask, 0);
        check("rst_set_h", set_hours, 0);
        check("rst_set_m", set_minutes, 0);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (run_en !== 1'b1 || load !== 1'b0 || mode !== 2'd0 || blink_mask !== 2'd0 ||
                set_hours !== 5'd0 || set_minutes !== 6'd0) bad++;
            tick(1);
        end
        check("idle_hold_bad_cycles", bad, 0);

        // 2. bouncing mode button must not register
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            btn_mode = 1'b1;
            tick(2);
            if (mode !== 2'd0) bad++;
            btn_mode = 1'b0;
            tick(2);
            if (mode !== 2'd0) bad++;
        end
        tick(20);
        if (mode !== 2'd0) bad++;
        check("bounce_no_mode", bad, 0);

        // 3. 23:59 -> wrap both fields -> 00:00, single load
        cur_hours = 5'd23;
        cur_minutes = 6'd59;
        press(1'b1, 1'b0);
        check("t3_mode_seth", mode, 1);
        check("t3_run_en_low", run_en, 0);
        check("t3_cap_h", set_hours, 23);
        check("t3_cap_m", set_minutes, 59);
        press(1'b0, 1'b1);
        check("t3_h_wrap", set_hours, 0);
        press(1'b1, 1'b0);
        check("t3_mode_setm", mode, 2);
        check("t3_blink_m_phase1", blink_mask, 1);
        press(1'b0, 1'b1);
        check("t3_m_wrap", set_minutes, 0);
        check("t3_no_carry", set_hours, 0);
        check("t3_no_load_yet", load_cnt, 0);
        press(1'b1, 1'b0);
        check("t3_mode_run", mode, 0);
        check("t3_run_en_back", run_en, 1);
        check("t3_load_once", load_cnt, 1);
        check("t3_load_with_run_en", load_bad, 0);
        check("t3_blink_run", blink_mask, 0);
        cur_hours = 5'd5;
        cur_minutes = 6'd5;
        tick(5);
        check("t3_hold_h_in_run", set_hours, 0);
        check("t3_hold_m_in_run", set_minutes, 0);

        // 4. simultaneous mode+inc in SET_HOURS: mode wins
        cur_hours = 5'd7;
        cur_minutes = 6'd30;
        press(1'b1, 1'b0);
        check("t4_cap_h", set_hours, 7);
        check("t4_blink_h_phase1", blink_mask, 2);
        tick(8);
        check("t4_blink_h_phase0", blink_mask, 0);
        press(1'b1, 1'b1);
        check("t4_mode_setm", mode, 2);
        check("t4_h_unchanged", set_hours, 7);
        check("t4_m_unchanged", set_minutes, 30);
        press(1'b0, 1'b1);
        check("t4_m_inc", set_minutes, 31);
        press(1'b1, 1'b0);
        check("t4_load_count", load_cnt, 2);

        // 5. blink pattern in SET_MINUTES, then reset mid-edit
        press(1'b1, 1'b0);
        btn_mode = 1'b1;
        tick(8);
        btn_mode = 1'b0;
        check("t5_mode_setm", mode, 2);
        for (int k = 0; k < 40; k++) begin
            if (k % 4 == 0) check($sformatf("t5_blink_%0d", k), blink_mask, ((k / 8) % 2 == 1) ? 1 : 0);
            tick(1);
        end
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_mode", mode, 0);
        check("t5_rst_run_en", run_en, 1);
        check("t5_rst_blink", blink_mask, 0);
        tick(2);
        rst = 1'b0;
        tick(20);
        check("t5_no_load", load_cnt, 2);
        check("t5_rst_set_m", set_minutes, 0);

        // 6. hold increment in SET_MINUTES from 10
        do_reset();
        cur_hours = 5'd0;
        cur_minutes = 6'd10;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("t6_start_m", set_minutes, 10);
        btn_inc = 1'b1;
        tick(8);
        check("t6_first_inc", set_minutes, 11);
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        exp_rpt = 12;
`else
        exp_rpt = 11;
`endif
        tick(22);
        check("t6_mid_hold", set_minutes, exp_rpt);
        tick(27);
        btn_inc = 1'b0;
        tick(20);
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        exp_rpt = 14;
`else
        exp_rpt = 11;
`endif
        check("t6_after_release", set_minutes, exp_rpt);
        press(1'b1, 1'b0);
        check("t6_load", load_cnt, 3);

        // 7. out-of-range capture clamps to zero
        cur_hours = 5'd30;
        cur_minutes = 6'd61;
        press(1'b1, 1'b0);
        check("t7_clamp_h", set_hours, 0);
        check("t7_clamp_m", set_minutes, 0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("t7_load", load_cnt, 4);
        check("t7_mode_run", mode, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
